// File: rtl/dm_pkg.sv
// Debug module shared definitions: DMI register map, field positions,
// cmderr codes and abstract-command FSM states.
package dm_pkg;

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam int DMC_HALTREQ   = 31;
  localparam int DMC_RESUMEREQ = 30;
  localparam int DMC_NDMRESET  = 1;
  localparam int DMC_DMACTIVE  = 0;

  localparam int CMD_TRANSFER = 17;
  localparam int CMD_WRITE    = 16;

  localparam logic [3:0] DMS_VERSION   = 4'd2;
  localparam logic [3:0] ACS_DATACOUNT = 4'd1;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } cmd_state_e;

  // Only register access with 32-bit size is implemented.
  function automatic logic cmd_supported(input logic [31:0] c);
    return (c[31:24] == 8'h00) && (c[22:20] == 3'd2);
  endfunction

endpackage

// File: rtl/dm_abstract_cmd.sv
// Abstract register-access FSM driving the hart request/ack port.
// Optional ack timeout enabled by DM_CMD_TIMEOUT_EN.
module dm_abstract_cmd
  import dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        start,
  input  logic        start_we,
  input  logic [15:0] start_regno,
  input  logic [31:0] start_wdata,
  output logic        busy,
  output logic        set_exc,
  output logic        load_data0,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [15:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_ack_i,
  input  logic        reg_err_i
);

  cmd_state_e  state_q, state_d;
  logic        we_q;
  logic [15:0] regno_q;
  logic [31:0] wdata_q;
  logic        tmo;
  logic        in_req;

  assign in_req = (state_q == ST_REQ);

`ifdef DM_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!in_req) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo = in_req && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      regno_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start && state_q == ST_IDLE) begin
        we_q    <= start_we;
        regno_q <= start_regno;
        wdata_q <= start_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    set_exc    = 1'b0;
    load_data0 = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (reg_ack_i) begin
          state_d = ST_DONE;
          if (reg_err_i) set_exc = 1'b1;
          else if (!we_q) load_data0 = 1'b1;
        end else if (tmo) begin
          state_d = ST_DONE;
          set_exc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Deactivating the DM abandons any command in flight.
    if (clr) begin
      state_d    = ST_IDLE;
      set_exc    = 1'b0;
      load_data0 = 1'b0;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign reg_req_o   = in_req;
  assign reg_we_o    = in_req & we_q;
  assign reg_addr_o  = in_req ? regno_q : 16'h0;
  assign reg_wdata_o = in_req ? wdata_q : 32'h0;

endmodule

// File: rtl/wishbone_dm_slave.sv
// Wishbone classic slave exposing the RISC-V debug module register subset.
// Build option DM_CMD_TIMEOUT_EN adds an abstract-command ack timeout.
module wishbone_dm_slave
  import dm_pkg::*;
#(
  parameter int DMI_ABITS      = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        haltreq_o,
  output logic        resumereq_o,
  output logic        ndmreset_o,
  input  logic        hart_halted_i,
  input  logic        hart_running_i,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [15:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ack_i,
  input  logic        reg_err_i
);

  logic [DMI_ABITS-1:0] dmi_addr;
  logic        wr, wr_data0, wr_dmc, wr_acs, wr_cmd;
  logic        dmactive_q, resumeack_q;
  logic        clr, dmc_full;
  logic [31:0] data0_q;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        start, busy, set_exc, load_data0;
  logic [31:0] rdata;
  logic        unused_addr;

  assign dmi_addr    = addr_i[DMI_ABITS-1:0];
  assign unused_addr = ^addr_i[31:DMI_ABITS];

  assign wr       = ack_o & cyc_i & stb_i & we_i;
  assign wr_data0 = wr && dmi_addr == DMI_ABITS'(ADDR_DATA0);
  assign wr_dmc   = wr && dmi_addr == DMI_ABITS'(ADDR_DMCONTROL);
  assign wr_acs   = wr && dmi_addr == DMI_ABITS'(ADDR_ABSTRACTCS);
  assign wr_cmd   = wr && dmi_addr == DMI_ABITS'(ADDR_COMMAND);

  // While inactive, or being deactivated, all DM state is forced to reset.
  assign clr      = !dmactive_q || (wr_dmc && !data_i[DMC_DMACTIVE]);
  assign dmc_full = !clr && wr_dmc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_o <= 1'b0;
    else        ack_o <= cyc_i & stb_i & ~ack_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmactive_q  <= 1'b0;
      haltreq_o   <= 1'b0;
      ndmreset_o  <= 1'b0;
      resumereq_o <= 1'b0;
      resumeack_q <= 1'b0;
      data0_q     <= '0;
      cmderr_q    <= CMDERR_NONE;
    end else begin
      if (wr_dmc) dmactive_q <= data_i[DMC_DMACTIVE];
      cmderr_q <= cmderr_d;
      if (clr) begin
        haltreq_o   <= 1'b0;
        ndmreset_o  <= 1'b0;
        resumereq_o <= 1'b0;
        resumeack_q <= 1'b0;
        data0_q     <= '0;
      end else begin
        if (dmc_full) begin
          haltreq_o  <= data_i[DMC_HALTREQ];
          ndmreset_o <= data_i[DMC_NDMRESET];
        end
        if (dmc_full && data_i[DMC_RESUMEREQ] && !data_i[DMC_HALTREQ]) begin
          resumereq_o <= 1'b1;
          resumeack_q <= 1'b0;
        end else if (resumereq_o && hart_running_i) begin
          resumereq_o <= 1'b0;
          resumeack_q <= 1'b1;
        end
        if (load_data0)           data0_q <= reg_rdata_i;
        else if (wr_data0 && !busy) data0_q <= data_i;
      end
    end
  end

  always_comb begin
    cmderr_d = cmderr_q;
    start    = 1'b0;
    if (wr_data0 && busy && cmderr_q == CMDERR_NONE)
      cmderr_d = CMDERR_BUSY;
    if (wr_acs && !busy)
      cmderr_d = cmderr_q & ~data_i[10:8];
    if (wr_cmd) begin
      priority case (1'b1)
        busy: if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
        (cmderr_q != CMDERR_NONE): ;
        !cmd_supported(data_i): cmderr_d = CMDERR_NOTSUP;
        !hart_halted_i: cmderr_d = CMDERR_HALTRESUME;
        !data_i[CMD_TRANSFER]: ;
        default: start = 1'b1;
      endcase
    end
    if (set_exc) cmderr_d = CMDERR_EXCEPTION;
    if (clr) begin
      cmderr_d = CMDERR_NONE;
      start    = 1'b0;
    end
  end

  dm_abstract_cmd #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cmd (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .start      (start),
    .start_we   (data_i[CMD_WRITE]),
    .start_regno(data_i[15:0]),
    .start_wdata(data0_q),
    .busy       (busy),
    .set_exc    (set_exc),
    .load_data0 (load_data0),
    .reg_req_o  (reg_req_o),
    .reg_we_o   (reg_we_o),
    .reg_addr_o (reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_ack_i  (reg_ack_i),
    .reg_err_i  (reg_err_i)
  );

  always_comb begin
    rdata = 32'h0;
    case (dmi_addr)
      DMI_ABITS'(ADDR_DATA0): rdata = data0_q;
      DMI_ABITS'(ADDR_DMCONTROL): begin
        rdata[DMC_HALTREQ]  = haltreq_o;
        rdata[DMC_NDMRESET] = ndmreset_o;
        rdata[DMC_DMACTIVE] = dmactive_q;
      end
      DMI_ABITS'(ADDR_DMSTATUS): begin
        rdata[3:0]   = DMS_VERSION;
        rdata[7]     = 1'b1;
        rdata[9:8]   = {2{hart_halted_i}};
        rdata[11:10] = {2{hart_running_i}};
        rdata[17:16] = {2{resumeack_q}};
      end
      DMI_ABITS'(ADDR_ABSTRACTCS): begin
        rdata[3:0]  = ACS_DATACOUNT;
        rdata[10:8] = cmderr_q;
        rdata[12]   = busy;
      end
      default: rdata = 32'h0;
    endcase
  end

  assign data_o = ack_o ? rdata : 32'h0;

endmodule

// File: doc/wishbone_dm_slave.md
Name: wishbone_dm_slave

Overview:
Wishbone classic slave implementing the RISC-V Debug Module register subset behind the JTAG dmi path. The JTAG-driven wishbone master reads and writes this block. It drives halt/resume requests and abstract register-access commands toward a single hart over a simple request/ack port.

Parameters:
DMI_ABITS, 7, DMI address width taken from addr_i[DMI_ABITS-1:0] (word address, no byte offset)
TIMEOUT_CYCLES, 1024, abstract-command ack timeout (used only with DM_CMD_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr_i  input  32  wishbone address; bits [DMI_ABITS-1:0] decoded
we_i  input  1  wishbone write enable
data_i  input  32  wishbone write data
cyc_i  input  1  wishbone cycle
stb_i  input  1  wishbone strobe
data_o  output  32  wishbone read data, valid while ack_o=1
ack_o  output  1  wishbone acknowledge
haltreq_o  output  1  halt request level to hart
resumereq_o  output  1  resume request, held until hart reports running
ndmreset_o  output  1  system reset request (dmcontrol.ndmreset)
hart_halted_i  input  1  hart is halted
hart_running_i  input  1  hart is running
reg_req_o  output  1  abstract register access request, held until reg_ack_i
reg_we_o  output  1  1 = write hart register from data0
reg_addr_o  output  16  regno
reg_wdata_o  output  32  data0 snapshot
reg_rdata_i  input  32  hart register read data, valid with reg_ack_i
reg_ack_i  input  1  one-cycle completion pulse
reg_err_i  input  1  exception flag, valid with reg_ack_i

Behaviour:
- Reset: all outputs 0, data0=0, dmcontrol=0, cmderr=0, FSM IDLE, resumeack=0.
- Bus: ack_o registered; asserted the cycle after cyc_i&stb_i while ack_o=0, so exactly one 1-cycle ack per access. Register side effects occur on the acked cycle. Unmapped addresses read 0, writes ignored, still acked.
- 0x04 data0: RW. Write while busy -> ignored, cmderr=1 if cmderr==0.
- 0x10 dmcontrol: [31] haltreq RW, [30] resumereq W1 (reads 0), [1] ndmreset RW, [0] dmactive RW. While dmactive=0, writes update only dmactive and other DM state is held at reset values.
- 0x11 dmstatus RO:
  - [3:0]=2, [7]=1 authenticated
  - [9:8] all/anyhalted = hart_halted_i
  - [11:10] all/anyrunning = hart_running_i
  - [17:16] all/anyresumeack = resumeack
- Resume: write with resumereq=1 and haltreq=0 -> resumeack=0, resumereq_o=1. When hart_running_i=1 is seen while resumereq_o=1 -> resumereq_o=0, resumeack=1 the next cycle. haltreq_o = dmcontrol.haltreq.
- 0x16 abstractcs:
  - [3:0] datacount=1, [12] busy, [28:24] progbufsize=0
  - [10:8] cmderr, write-1-to-clear per bit; ignored while busy.
- 0x17 command (write-only, reads 0). Write checks, in priority order:
  - busy -> cmderr=1 if cmderr==0
  - cmderr!=0 -> ignored
  - cmdtype[31:24]!=0 or aarsize[22:20]!=2 -> cmderr=2
  - hart_halted_i=0 -> cmderr=4
  - transfer[17]=0 -> no-op, no busy
  - otherwise IDLE->REQ.
- FSM IDLE/REQ/DONE:
  - REQ: reg_req_o=1, reg_we_o=write[16], reg_addr_o=regno, reg_wdata_o=data0, busy=1.
  - reg_ack_i in REQ -> DONE. If reg_err_i, cmderr=3. Else, on reads, data0<=reg_rdata_i.
  - DONE -> IDLE next cycle, busy=0. reg_ack_i outside REQ is ignored.
- dmactive write 0 mid-command: FSM returns to IDLE at once, reg_req_o=0, a later reg_ack_i is ignored.
- Bus write and reg_ack_i to data0 in the same cycle: reg_ack_i wins; the bus write sets cmderr=1.

Optional Feature:
DM_CMD_TIMEOUT_EN: a counter runs in REQ. At TIMEOUT_CYCLES without reg_ack_i -> reg_req_o=0, cmderr=3, FSM to DONE. Without the macro, REQ waits indefinitely.

Decomposition:
- Package dm_pkg: DMI register addresses, dmcontrol/dmstatus/abstractcs/command field positions, cmderr codes (NONE=0, BUSY=1, NOTSUP=2, EXCEPTION=3, HALTRESUME=4), FSM state encoding.
- One sub-module, dm_abstract_cmd: command FSM, hart request port, timeout counter.

Test Plan:
- Write dmcontrol=0x1, then 0x80000001 -> haltreq_o=1. With hart_halted_i=1, dmstatus reads 0x00000382.
- Halted hart: write data0=0xDEADBEEF, command=0x00231001 -> reg_req_o, reg_we_o=1, reg_addr_o=0x1001, reg_wdata_o=0xDEADBEEF. Ack -> busy clears, cmderr=0.
- Read command 0x00221002, hart acks with reg_rdata_i=0x12345678 -> data0 reads 0x12345678.
- Command while busy -> cmderr=1. Command 0x01000000 with cmderr=0 -> cmderr=2. Write abstractcs=0x700 -> cmderr=0.
- Write dmcontrol=0x40000001; raise hart_running_i after 5 cycles -> resumereq_o drops, dmstatus[17:16]=2'b11. Then reg_err_i on an access -> cmderr=3.
- With DM_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, never ack -> reg_req_o drops after 16 cycles, cmderr=3. Assert rst_n=0 mid-command -> all outputs 0 immediately.
